// File: rtl/leg_pkg.sv
// Shared types and constants for the LEG decode stage and its opcode classifier.
package leg_pkg;

   // Byte slot that the next accepted program byte will fill.
   typedef enum logic [1:0] {
      PH_OP  = 2'd0,
      PH_A1  = 2'd1,
      PH_A2  = 2'd2,
      PH_DST = 2'd3
   } phase_t;

   // Instruction class codes. Calc and mem match opcode[5:4] directly.
   // Jump is a window that can straddle classes, so it is resolved separately.
   localparam logic [1:0] CLS_CALC = 2'b00;
   localparam logic [1:0] CLS_MEM  = 2'b01;
   localparam logic [1:0] CLS_JUMP = 2'b10;
   localparam logic [1:0] CLS_ILL  = 2'b11;

   // Operand width of the default LEG machine.
   localparam int LEG_ARG_W = 8;

   // Decoded opcode: one-hot class flags, raw immediate bits and function field.
   typedef struct packed {
      logic       imm1;
      logic       imm2;
      logic       calc;
      logic       jump;
      logic       mem;
      logic       illegal;
      logic [3:0] func;
   } dec_flags_t;

   // Complete decoded instruction as the default 8-bit machine sees it.
   typedef struct packed {
      dec_flags_t           flags;
      logic [LEG_ARG_W-1:0] arg1;
      logic [LEG_ARG_W-1:0] arg2;
      logic [LEG_ARG_W-1:0] dest;
   } leg_instr_t;

endpackage

// File: rtl/leg_opcode_classify.sv
// Purely combinational LEG opcode classifier: opcode byte -> class flags and function.
module leg_opcode_classify
   import leg_pkg::*;
#(
   parameter logic [5:0]  JUMP_BASE = 6'h20,
   parameter int unsigned NUM_COND  = 6,
   parameter int unsigned NUM_MEMOP = 6
) (
   input  logic [7:0] opcode,
   output dec_flags_t flags
);

   logic [6:0] low7;
   logic [6:0] jump_lo;
   logic [6:0] jump_hi;
   logic [3:0] jump_idx;
   logic [1:0] cls;

   // The jump window is compared with one spare bit so base+count cannot wrap.
   assign low7    = {1'b0, opcode[5:0]};
   assign jump_lo = {1'b0, JUMP_BASE};
   assign jump_hi = jump_lo + 7'(NUM_COND);

   // Jump index only ever spans 0..15, so the low nibbles give it modulo 16.
   assign jump_idx = opcode[3:0] - JUMP_BASE[3:0];

   // Pick one class; jump is checked first so it wins over any overlapping class.
   always_comb begin
      cls = CLS_ILL;
      if ((low7 >= jump_lo) && (low7 < jump_hi)) begin
         cls = CLS_JUMP;
      end else if (opcode[5:4] == CLS_CALC) begin
         cls = CLS_CALC;
      end else if ((opcode[5:4] == CLS_MEM) && ({1'b0, opcode[3:0]} < 5'(NUM_MEMOP))) begin
         cls = CLS_MEM;
      end
   end

   // Expand the class into one-hot flags and select the function field.
   always_comb begin
      flags         = '0;
      flags.imm1    = opcode[7];
      flags.imm2    = opcode[6];
      flags.calc    = (cls == CLS_CALC);
      flags.jump    = (cls == CLS_JUMP);
      flags.mem     = (cls == CLS_MEM);
      flags.illegal = (cls == CLS_ILL);
      flags.func    = (cls == CLS_JUMP) ? jump_idx : opcode[3:0];
   end

endmodule

// File: rtl/leg_decode_stage.sv
// Registered, handshaked LEG decode stage: assembles OP/A1/A2/DST bytes and
// presents the decoded instruction from a one-entry valid/ready output register.
module leg_decode_stage
   import leg_pkg::*;
#(
   parameter int unsigned DATA_W    = 8,
   parameter logic [5:0]  JUMP_BASE = 6'h20,
   parameter int unsigned NUM_COND  = 6,
   parameter int unsigned NUM_MEMOP = 6
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              flush,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DATA_W-1:0] in_byte,
   output logic              out_valid,
   input  logic              out_ready,
   output logic              out_imm1,
   output logic              out_imm2,
   output logic              out_calc,
   output logic              out_jump,
   output logic              out_mem,
   output logic              out_illegal,
   output logic [3:0]        out_func,
   output logic [DATA_W-1:0] out_arg1,
   output logic [DATA_W-1:0] out_arg2,
   output logic [DATA_W-1:0] out_dest,
   output logic [1:0]        phase
);

   phase_t            phase_q;
   phase_t            phase_nxt;
   logic [7:0]        op_q;
   logic [DATA_W-1:0] a1_q;
   logic [DATA_W-1:0] a2_q;
   logic              accept;
   logic              complete;
   dec_flags_t        dec;

   // Only the DST byte can stall, and only while an unconsumed result is held.
   assign in_ready = (phase_q != PH_DST) || !out_valid || out_ready;
   assign accept   = in_valid && in_ready;
   assign complete = accept && (phase_q == PH_DST);
   assign phase    = phase_q;

   leg_opcode_classify #(
      .JUMP_BASE (JUMP_BASE),
      .NUM_COND  (NUM_COND),
      .NUM_MEMOP (NUM_MEMOP)
   ) u_classify (
      .opcode (op_q),
      .flags  (dec)
   );

   // Byte-slot sequencing: step to the next slot on every accepted byte.
   always_comb begin
      phase_nxt = phase_q;
      if (accept) begin
         unique case (phase_q)
            PH_OP:   phase_nxt = PH_A1;
            PH_A1:   phase_nxt = PH_A2;
            PH_A2:   phase_nxt = PH_DST;
            PH_DST:  phase_nxt = PH_OP;
            default: phase_nxt = PH_OP;
         endcase
      end
   end

   // Slot state register; flush abandons any partial instruction.
   always_ff @(posedge clk) begin
      if (!rst) begin
         phase_q <= PH_OP;
      end else if (flush) begin
         phase_q <= PH_OP;
      end else begin
         phase_q <= phase_nxt;
      end
   end

   // Capture the opcode and first two operands into their holding registers.
   always_ff @(posedge clk) begin
      if (!rst) begin
         op_q <= '0;
         a1_q <= '0;
         a2_q <= '0;
      end else if (!flush && accept) begin
         unique case (phase_q)
            PH_OP:   op_q <= in_byte[7:0];
            PH_A1:   a1_q <= in_byte;
            PH_A2:   a2_q <= in_byte;
            default: ;
         endcase
      end
   end

   // Output register: load on completion, drop valid on a consumed result,
   // and keep the data fields untouched across a flush.
   always_ff @(posedge clk) begin
      if (!rst) begin
         out_valid   <= 1'b0;
         out_imm1    <= 1'b0;
         out_imm2    <= 1'b0;
         out_calc    <= 1'b0;
         out_jump    <= 1'b0;
         out_mem     <= 1'b0;
         out_illegal <= 1'b0;
         out_func    <= '0;
         out_arg1    <= '0;
         out_arg2    <= '0;
         out_dest    <= '0;
      end else if (flush) begin
         out_valid <= 1'b0;
      end else if (complete) begin
         out_valid   <= 1'b1;
         out_imm1    <= dec.imm1;
         out_imm2    <= dec.imm2;
         out_calc    <= dec.calc;
         out_jump    <= dec.jump;
         out_mem     <= dec.mem;
         out_illegal <= dec.illegal;
         out_func    <= dec.func;
         out_arg1    <= a1_q;
         out_arg2    <= a2_q;
         out_dest    <= in_byte;
      end else if (out_valid && out_ready) begin
         out_valid <= 1'b0;
      end
   end

endmodule

// File: tb/tb_leg_decode_stage.sv
// Scoreboard bench for leg_decode_stage with a behavioural decode model.
module tb_leg_decode_stage;

   localparam int DATA_W    = 8;
   localparam int JUMP_BASE = 32;
   localparam int NUM_COND  = 6;
   localparam int NUM_MEMOP = 6;

   logic              clk = 1'b0;
   logic              rst;
   logic              flush;
   logic              in_valid;
   logic              in_ready;
   logic [DATA_W-1:0] in_byte;
   logic              out_valid;
   logic              out_ready;
   logic              out_imm1;
   logic              out_imm2;
   logic              out_calc;
   logic              out_jump;
   logic              out_mem;
   logic              out_illegal;
   logic [3:0]        out_func;
   logic [DATA_W-1:0] out_arg1;
   logic [DATA_W-1:0] out_arg2;
   logic [DATA_W-1:0] out_dest;
   logic [1:0]        phase;

   int checks = 0;
   int errors = 0;

   // Model state: bytes collected so far, whether a result is pending, and the
   // expected results in the order they should be consumed.
   int              m_cnt  = 0;
   bit              m_pend = 0;
   bit [7:0]        m_slot [4];
   logic [63:0]     sb [$];
   bit              m_ready_pre;

   leg_decode_stage #(
      .DATA_W    (DATA_W),
      .JUMP_BASE (6'h20),
      .NUM_COND  (NUM_COND),
      .NUM_MEMOP (NUM_MEMOP)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .flush       (flush),
      .in_valid    (in_valid),
      .in_ready    (in_ready),
      .in_byte     (in_byte),
      .out_valid   (out_valid),
      .out_ready   (out_ready),
      .out_imm1    (out_imm1),
      .out_imm2    (out_imm2),
      .out_calc    (out_calc),
      .out_jump    (out_jump),
      .out_mem     (out_mem),
      .out_illegal (out_illegal),
      .out_func    (out_func),
      .out_arg1    (out_arg1),
      .out_arg2    (out_arg2),
      .out_dest    (out_dest),
      .phase       (phase)
   );

   always #5 clk = ~clk;

   // Reference decode computed from the class rules with plain integer arithmetic.
   function automatic logic [63:0] ref_decode(input bit [7:0] op, input bit [7:0] a1,
                                              input bit [7:0] a2, input bit [7:0] d);
      int low;
      int grp;
      bit c, j, m, il;
      int f;
      low = op % 64;
      grp = low / 16;
      c = 0; j = 0; m = 0; il = 0;
      f = low % 16;
      if (low >= JUMP_BASE && low < JUMP_BASE + NUM_COND) begin
         j = 1;
         f = low - JUMP_BASE;
      end else if (grp == 0) begin
         c = 1;
      end else if (grp == 1 && (low % 16) < NUM_MEMOP) begin
         m = 1;
      end else begin
         il = 1;
      end
      return {30'd0, op[7], op[6], c, j, m, il, 4'(f), a1, a2, d};
   endfunction

   function automatic logic [63:0] dut_vector();
      return {30'd0, out_imm1, out_imm2, out_calc, out_jump, out_mem, out_illegal,
              out_func, out_arg1, out_arg2, out_dest};
   endfunction

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic drive(input bit v, input bit [7:0] b, input bit ordy, input bit fl);
      in_valid  = v;
      in_byte   = b;
      out_ready = ordy;
      flush     = fl;
   endtask

   // One clock: check handshake/phase before the edge, then advance the model.
   task automatic step();
      bit acc;
      bit cmp;
      @(negedge clk);
      m_ready_pre = (m_cnt != 3) || !m_pend || out_ready;
      if (rst) begin
         check("in_ready", {63'd0, in_ready}, {63'd0, m_ready_pre});
         check("phase", {62'd0, phase}, 64'(m_cnt));
         check("out_valid", {63'd0, out_valid}, {63'd0, m_pend});
      end
      @(posedge clk);
      if (!rst || flush) begin
         m_cnt  = 0;
         m_pend = 0;
         sb.delete();
      end else begin
         acc = in_valid && m_ready_pre;
         cmp = 0;
         if (acc) begin
            m_slot[m_cnt] = in_byte;
            if (m_cnt == 3) begin
               sb.push_back(ref_decode(m_slot[0], m_slot[1], m_slot[2], m_slot[3]));
               cmp = 1;
            end
            m_cnt = (m_cnt + 1) % 4;
         end
         if (cmp) m_pend = 1;
         else if (m_pend && out_ready) m_pend = 0;
      end
      #1;
   endtask

   task automatic send_instr(input bit [7:0] op, input bit [7:0] a1, input bit [7:0] a2,
                             input bit [7:0] d, input bit ordy);
      drive(1, op, ordy, 0); step();
      drive(1, a1, ordy, 0); step();
      drive(1, a2, ordy, 0); step();
      drive(1, d,  ordy, 0); step();
   endtask

   // Monitor: compare each consumed result against the scoreboard and verify
   // that a stalled result stays frozen.
   logic [63:0] held_vec;
   bit          held = 0;
   always @(negedge clk) begin
      if (rst === 1'b1 && flush === 1'b0) begin
         if (held) check("hold_stable", dut_vector(), held_vec);
         if (out_valid && out_ready) begin
            if (sb.size() == 0) begin
               check("unexpected_output", 64'd1, 64'd0);
            end else begin
               check("decode", dut_vector(), sb.pop_front());
            end
         end
         held     = out_valid && !out_ready;
         held_vec = dut_vector();
      end else begin
         held = 0;
      end
   end

   // Stimulus: reset, directed scenarios, then randomized traffic.
   initial begin
      bit hold_byte;
      rst = 1'b0;
      drive(0, 8'h00, 1, 0);
      step();
      step();
      rst = 1'b1;
      @(negedge clk);
      check("reset_phase", {62'd0, phase}, 64'd0);
      check("reset_valid", {63'd0, out_valid}, 64'd0);
      check("reset_ready", {63'd0, in_ready}, 64'd1);
      check("reset_fields", dut_vector(), 64'd0);
      @(posedge clk);
      #1;

      send_instr(8'h03, 8'h05, 8'h07, 8'h02, 1);
      send_instr(8'hE4, 8'h11, 8'h22, 8'h33, 1);
      send_instr(8'h26, 8'h44, 8'h55, 8'h66, 1);
      send_instr(8'h45, 8'h01, 8'h02, 8'h03, 1);
      send_instr(8'h46, 8'h04, 8'h05, 8'h06, 1);
      drive(0, 8'h00, 1, 0); step();

      send_instr(8'h12, 8'hA1, 8'hA2, 8'hA3, 0);
      drive(1, 8'h21, 0, 0); step();
      drive(1, 8'hB1, 0, 0); step();
      drive(1, 8'hB2, 0, 0); step();
      repeat (5) begin
         drive(1, 8'hB3, 0, 0); step();
      end
      drive(1, 8'hB3, 1, 0); step();
      drive(0, 8'h00, 1, 0); step();
      step();

      drive(1, 8'h01, 1, 0); step();
      drive(1, 8'h02, 1, 0); step();
      drive(1, 8'h03, 1, 1); step();
      send_instr(8'h35, 8'h0A, 8'h0B, 8'h0C, 0);
      drive(0, 8'h00, 0, 1); step();
      drive(0, 8'h00, 1, 0); step();

      for (int i = 0; i < 4000; i++) begin
         hold_byte = in_valid && !m_ready_pre && !flush;
         out_ready = ($urandom_range(0, 9) < 6);
         flush     = ($urandom_range(0, 59) == 0);
         if (!hold_byte) begin
            in_valid = ($urandom_range(0, 9) < 7);
            in_byte  = 8'($urandom());
         end
         step();
      end

      drive(0, 8'h00, 1, 0);
      step();
      step();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
